// File: rtl/pokey_timer_pkg.sv
// rtl/pokey_timer_pkg.sv - shared constants for the POKEY timer sequencer
//
// Purpose: register addresses, AUDCTL bit positions, prescaler divisor
// defaults and the fast-channel reload offset helper.
// Ports: none (package).
package pokey_timer_pkg;

  localparam logic [3:0] ADDR_AUDF0  = 4'h0;
  localparam logic [3:0] ADDR_AUDF1  = 4'h2;
  localparam logic [3:0] ADDR_AUDF2  = 4'h4;
  localparam logic [3:0] ADDR_AUDF3  = 4'h6;
  localparam logic [3:0] ADDR_AUDCTL = 4'h8;
  localparam logic [3:0] ADDR_STIMER = 4'h9;
  localparam logic [3:0] ADDR_IRQEN  = 4'hE;

  localparam int unsigned AUDCTL_CLK15  = 0;
  localparam int unsigned AUDCTL_LINK23 = 3;
  localparam int unsigned AUDCTL_LINK01 = 4;
  localparam int unsigned AUDCTL_FAST2  = 5;
  localparam int unsigned AUDCTL_FAST0  = 6;

  localparam int unsigned DIV64_DEFAULT = 28;
  localparam int unsigned DIV15_DEFAULT = 114;

  // The timer reports underflow three ce late; a fast channel preloads
  // three less so its period matches the programmed AUDF value.
  function automatic logic [7:0] fast_reload(input logic [7:0] audf);
    return (audf < 8'd3) ? 8'h00 : audf - 8'd3;
  endfunction

endpackage

// File: rtl/pokey_timer_prescaler.sv
// rtl/pokey_timer_prescaler.sv - base-clock divider with sync preset
//
// Purpose: 7-bit down-counter that wraps to DIV-1 after 0; tick is high
// while the counter sits at 0.
// Ports: clk, reset (sync, active-high), ce (advance), preset (load DIV-1
// regardless of ce), tick (base tick, not gated with ce).
module pokey_timer_prescaler #(
  parameter int unsigned DIV = 28
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic preset,
  output logic tick
);

  localparam logic [6:0] RELOAD = 7'(DIV - 1);

  logic [6:0] cnt_q, cnt_d;
  // After reset the counter sits at 0 but has not counted a period yet;
  // primed_q keeps that restart ce from being reported as a tick.
  logic       primed_q, primed_d;

  always_comb begin
    cnt_d    = cnt_q;
    primed_d = primed_q;
    if (preset) begin
      cnt_d    = RELOAD;
      primed_d = 1'b1;
    end else if (ce) begin
      primed_d = 1'b1;
      cnt_d    = (cnt_q == 7'd0) ? RELOAD : cnt_q - 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= 7'd0;
      primed_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
    end
  end

  assign tick = primed_q && (cnt_q == 7'd0);

endmodule

// File: rtl/pokey_timer_ctrl.sv
// rtl/pokey_timer_ctrl.sv - sequencer for the four POKEY countdown timers
//
// Purpose: decodes AUDF0-3/AUDCTL/STIMER/IRQEN writes, generates the 64 kHz
// and 15 kHz base ticks, and drives timer enables, load strobes, reload data
// and IRQ status. Register writes act in the clk they occur.
// Ports: clk, reset (sync, active-high), ce (1.79 MHz enable), wr_en/addr/
// data_in (CPU write), timer_underflow[3:0] (in), timer_enable[3:0],
// timer_load[3:0], timer_data[31:0] (byte i -> timer i), irq_status[3:0], irq.
// Option: define POKEY_TIMER_FAST_OFFSET_EN to preload fast channels with
// AUDF-3 (saturating) instead of the raw AUDF value.
module pokey_timer_ctrl
  import pokey_timer_pkg::*;
#(
  parameter int unsigned DIV64 = DIV64_DEFAULT,
  parameter int unsigned DIV15 = DIV15_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        wr_en,
  input  logic [3:0]  addr,
  input  logic [7:0]  data_in,
  input  logic [3:0]  timer_underflow,
  output logic [3:0]  timer_enable,
  output logic [3:0]  timer_load,
  output logic [31:0] timer_data,
  output logic [3:0]  irq_status,
  output logic        irq
);

  logic [3:0][7:0] audf_q, audf_d;
  logic            clk15_q, clk15_d, link23_q, link23_d, link01_q, link01_d;
  logic            fast2_q, fast2_d, fast0_q, fast0_d;
  logic [3:0]      irqen_q, irqen_d;
  logic [3:0]      status_q, status_d;
  logic            irq_q;
  logic            stimer;
  logic            tick64, tick15, base_tick;
  logic [3:0]      en_c, load_c, irq_ev;
  logic [31:0]     data_c;

  always_comb begin
    audf_d   = audf_q;
    clk15_d  = clk15_q;
    link23_d = link23_q;
    link01_d = link01_q;
    fast2_d  = fast2_q;
    fast0_d  = fast0_q;
    irqen_d  = irqen_q;
    stimer   = 1'b0;
    if (wr_en) begin
      case (addr)
        ADDR_AUDF0:  audf_d[0] = data_in;
        ADDR_AUDF1:  audf_d[1] = data_in;
        ADDR_AUDF2:  audf_d[2] = data_in;
        ADDR_AUDF3:  audf_d[3] = data_in;
        ADDR_AUDCTL: begin
          clk15_d  = data_in[AUDCTL_CLK15];
          link23_d = data_in[AUDCTL_LINK23];
          link01_d = data_in[AUDCTL_LINK01];
          fast2_d  = data_in[AUDCTL_FAST2];
          fast0_d  = data_in[AUDCTL_FAST0];
        end
        ADDR_STIMER: stimer = 1'b1;
        ADDR_IRQEN:  irqen_d = data_in[3:0];
        default: ;
      endcase
    end
  end

  pokey_timer_prescaler #(.DIV(DIV64)) u_pre64 (
    .clk(clk), .reset(reset), .ce(ce), .preset(stimer), .tick(tick64)
  );

  pokey_timer_prescaler #(.DIV(DIV15)) u_pre15 (
    .clk(clk), .reset(reset), .ce(ce), .preset(stimer), .tick(tick15)
  );

  always_comb begin
    base_tick = clk15_d ? tick15 : tick64;

    // A linked high channel is clocked by the low channel's underflow.
    en_c[0] = ce & (fast0_d | base_tick);
    en_c[1] = ce & (link01_d ? timer_underflow[0] : base_tick);
    en_c[2] = ce & (fast2_d | base_tick);
    en_c[3] = ce & (link23_d ? timer_underflow[2] : base_tick);

    // In a linked pair only the high channel's underflow reloads, and it
    // reloads both halves; the low half free-wraps otherwise.
    load_c = 4'b0000;
    if (stimer) begin
      load_c = 4'b1111;
    end else if (ce) begin
      load_c[0] = link01_d ? timer_underflow[1] : timer_underflow[0];
      load_c[1] = timer_underflow[1];
      load_c[2] = link23_d ? timer_underflow[3] : timer_underflow[2];
      load_c[3] = timer_underflow[3];
    end

    irq_ev = 4'b0000;
    if (ce) begin
      irq_ev = {timer_underflow[3], timer_underflow[2] & ~link23_d,
                timer_underflow[1], timer_underflow[0] & ~link01_d};
    end
    // Masking after the set makes an IRQEN clear win over a coincident set.
    status_d = (status_q | irq_ev) & irqen_d;

    data_c = audf_d;
`ifdef POKEY_TIMER_FAST_OFFSET_EN
    if (fast0_d) data_c[7:0]   = fast_reload(audf_d[0]);
    if (fast2_d) data_c[23:16] = fast_reload(audf_d[2]);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      audf_q   <= '0;
      clk15_q  <= 1'b0;
      link23_q <= 1'b0;
      link01_q <= 1'b0;
      fast2_q  <= 1'b0;
      fast0_q  <= 1'b0;
      irqen_q  <= 4'b0000;
      status_q <= 4'b0000;
      irq_q    <= 1'b0;
    end else begin
      audf_q   <= audf_d;
      clk15_q  <= clk15_d;
      link23_q <= link23_d;
      link01_q <= link01_d;
      fast2_q  <= fast2_d;
      fast0_q  <= fast0_d;
      irqen_q  <= irqen_d;
      status_q <= status_d;
      irq_q    <= |status_q;
    end
  end

  assign timer_enable = reset ? 4'b0000 : en_c;
  assign timer_load   = reset ? 4'b0000 : load_c;
  assign timer_data   = reset ? 32'h0   : data_c;
  assign irq_status   = status_q;
  assign irq          = irq_q;

endmodule
